// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch-stage definitions: reset vector, sequential step and the
// fetch packet handed to decode.
package inst_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } fetch_pkt_t;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/inst_fetch_unit_hold_buffer.sv
// Single-entry packet store that keeps a stalled packet stable while the
// RAM keeps re-reading the next address underneath it.
module inst_hold_buffer
    import inst_fetch_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_capture,
    input  logic       i_clear,
    input  fetch_pkt_t i_pkt,
    output fetch_pkt_t o_pkt
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_inst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc    <= 32'd0;
            r_inst  <= 32'd0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_capture && !r_valid && i_pkt.valid) begin
            // Only the first stalled cycle captures; later cycles would
            // load the re-read of the following address.
            r_valid <= 1'b1;
            r_pc    <= i_pkt.pc;
            r_inst  <= i_pkt.inst;
        end
    end

    always_comb begin
        o_pkt = i_pkt;
        if (r_valid) begin
            o_pkt.valid = 1'b1;
            o_pkt.pc    = r_pc;
            o_pkt.inst  = r_inst;
            o_pkt.adel  = pc_misaligned(r_pc);
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the RAM instruction port and
// pairs the 1-cycle read data with its PC for decode.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_adel
);

    logic [31:0] r_pc;
    logic [31:0] r_resp_pc;
    logic        r_resp_valid;

    fetch_pkt_t  w_resp_pkt;
    fetch_pkt_t  w_out_pkt;
    logic        w_capture;
    logic        w_clear;

    assign inst_addr = redirect_valid ? redirect_pc : r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_resp_pc    <= 32'd0;
            r_resp_valid <= 1'b0;
        end else if (redirect_valid) begin
            r_pc         <= redirect_pc + PC_STEP;
            r_resp_pc    <= redirect_pc;
            r_resp_valid <= 1'b1;
        end else if (stall) begin
            // PC holds; the RAM re-reads it so the response is fresh on release.
            r_resp_pc    <= r_pc;
            r_resp_valid <= 1'b1;
        end else begin
            r_pc         <= r_pc + PC_STEP;
            r_resp_pc    <= r_pc;
            r_resp_valid <= 1'b1;
        end
    end

    always_comb begin
        w_resp_pkt.valid = r_resp_valid;
        w_resp_pkt.pc    = r_resp_pc;
        w_resp_pkt.inst  = inst_data;
        w_resp_pkt.adel  = r_resp_valid & pc_misaligned(r_resp_pc);
    end

    assign w_capture = stall & ~redirect_valid;
    assign w_clear   = redirect_valid | ~stall;

    inst_hold_buffer u_hold (
        .clk       (clk),
        .rst       (rst),
        .i_capture (w_capture),
        .i_clear   (w_clear),
        .i_pkt     (w_resp_pkt),
        .o_pkt     (w_out_pkt)
    );

    assign if_valid = w_out_pkt.valid;
    assign if_pc    = w_out_pkt.pc;
    assign if_inst  = w_out_pkt.inst;
    assign if_adel  = w_out_pkt.valid & w_out_pkt.adel;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit with a synchronous-read RAM model.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adel;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    inst_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_addr      (inst_addr),
        .inst_data      (inst_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_adel        (if_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        logic [14:0] idx;
        idx = a[16:2];
        return 32'h1000_0000 + {17'd0, idx};
    endfunction

    initial inst_data = 32'd0;
    always @(posedge clk) inst_data <= ram_word(inst_addr);

    function automatic void push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = ram_word(pc);
        e.adel = (pc[1:0] != 2'b00);
        exp_q.push_back(e);
    endfunction

    // One clock: drive inputs just after the edge, check the shown packet at negedge.
    task automatic cycle(input logic s, input logic r, input logic [31:0] rpc);
        exp_t e;
        @(posedge clk);
        #1;
        stall          = s;
        redirect_valid = r;
        redirect_pc    = rpc;
        @(negedge clk);
        if (r) begin
            checks++;
            if (inst_addr !== rpc) begin
                failures++;
                $display("FAIL redirect_addr got=%h exp=%h", inst_addr, rpc);
            end
            exp_q.delete();
        end else if (exp_q.size() == 0) begin
            if (if_valid === 1'b1) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pkt got_pc=%h exp=none", if_pc);
            end
        end else begin
            e = exp_q[0];
            checks++;
            if (if_valid !== 1'b1 || if_pc !== e.pc || if_inst !== e.inst || if_adel !== e.adel) begin
                failures++;
                $display("FAIL pkt got v=%b pc=%h inst=%h adel=%b exp v=1 pc=%h inst=%h adel=%b",
                         if_valid, if_pc, if_inst, if_adel, e.pc, e.inst, e.adel);
            end
            if (!s) void'(exp_q.pop_front());
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain got=%0d pending exp=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b0 || if_pc !== 32'd0 || if_adel !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b pc=%h adel=%b exp v=0 pc=0 adel=0", if_valid, if_pc, if_adel);
        end
        checks++;
        if (inst_addr !== 32'hBFC0_0000) begin
            failures++;
            $display("FAIL reset_addr got=%h exp=bfc00000", inst_addr);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0) begin
            failures++;
            $display("FAIL first_cycle_bubble got=%b exp=0", if_valid);
        end
    endtask

    task automatic test_sequential;
        push_exp(32'hBFC0_0000);
        push_exp(32'hBFC0_0004);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check_drained("sequential");
    endtask

    task automatic test_stall_release;
        push_exp(32'hBFC0_0008);
        push_exp(32'hBFC0_000C);
        push_exp(32'hBFC0_0010);
        repeat (3) cycle(1, 0, 0);
        repeat (3) cycle(0, 0, 0);
        check_drained("stall_release");
    endtask

    task automatic test_redirect;
        cycle(0, 1, 32'h8000_0100);
        push_exp(32'h8000_0100);
        push_exp(32'h8000_0104);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check_drained("redirect");
    endtask

    task automatic test_redirect_over_hold;
        push_exp(32'h8000_0108);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 1, 32'h8000_0200);
        push_exp(32'h8000_0200);
        push_exp(32'h8000_0204);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check_drained("redirect_over_hold");
    endtask

    task automatic test_misaligned;
        cycle(0, 1, 32'h8000_0102);
        push_exp(32'h8000_0102);
        push_exp(32'h8000_0106);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check_drained("misaligned");
    endtask

    task automatic test_wrap;
        cycle(0, 1, 32'hFFFF_FFFC);
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0000_0000);
        push_exp(32'h0000_0004);
        repeat (3) cycle(0, 0, 0);
        check_drained("wrap");
    endtask

    task automatic test_reset_mid_stall;
        push_exp(32'h0000_0008);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (if_valid !== 1'b0 || if_pc !== 32'd0 || if_adel !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_stall got v=%b pc=%h adel=%b exp v=0 pc=0 adel=0", if_valid, if_pc, if_adel);
        end
        exp_q.delete();
        @(negedge clk);
        stall = 1'b0;
        rst   = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0) begin
            failures++;
            $display("FAIL restart_bubble got=%b exp=0", if_valid);
        end
        push_exp(32'hBFC0_0000);
        push_exp(32'hBFC0_0004);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check_drained("restart");
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_release();
        test_redirect();
        test_redirect_over_hold();
        test_misaligned();
        test_wrap();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction fetch stage directly upstream of the unified block-RAM wrapper's instruction port. It owns the PC and drives the instruction read address each cycle. It pairs the RAM's 1-cycle synchronous read data with the PC that produced it, and presents a valid fetch packet to decode. A hold buffer keeps the packet stable across decode stalls; branch/exception redirects kill in-flight fetches.

Parameters:
RESET_PC, 32'hBFC0_0000, first fetch address after reset
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
stall  input  1  decode cannot accept the current packet; hold it
redirect_valid  input  1  redirect fetch to redirect_pc (branch/exception/eret)
redirect_pc  input  32  redirect target address
inst_addr  output  32  byte address to RAM instruction port (RAM uses bits [16:2])
inst_data  input  32  RAM read data, for the address driven in the previous cycle
if_valid  output  1  fetch packet valid
if_pc  output  32  PC of packet
if_inst  output  32  instruction word of packet
if_adel  output  1  packet PC misaligned (if_pc[1:0] != 0), address-error-on-load

Behaviour:
- Registers: pc_q (next address to issue), resp_pc_q/resp_valid_q (tracks the address whose data is on inst_data), hold_valid_q/hold_pc_q/hold_inst_q.
- Reset (async): pc_q=RESET_PC, resp_valid_q=0, hold_valid_q=0, resp_pc_q=0, hold_pc_q=0, hold_inst_q=0. Outputs during reset: if_valid=0, if_pc=0, if_inst=inst_data (don't-care), if_adel=0, inst_addr=RESET_PC unless redirect_valid.
- inst_addr (combinational) = redirect_valid ? redirect_pc : pc_q.
- Outputs (combinational): if_valid = hold_valid_q | resp_valid_q. If hold_valid_q then if_pc/if_inst come from hold_pc_q/hold_inst_q, else from resp_pc_q/inst_data. if_adel = if_valid & (if_pc[1:0] != 0).
- Priority per clock edge: redirect > stall > advance.
- Redirect: pc_q <= redirect_pc+PC_STEP; resp_pc_q <= redirect_pc; resp_valid_q <= 1; hold_valid_q <= 0. This overrides stall. The packet shown in the redirect cycle is killed; decode ignores it.
- Stall (no redirect): pc_q holds. If resp_valid_q & !hold_valid_q, capture hold <= {resp_pc_q, inst_data} and set hold_valid_q. resp_pc_q <= pc_q; resp_valid_q <= 1. The RAM re-reads pc_q every stalled cycle; reads have no side effects. If if_valid=0 (post-reset), no capture and resp_valid_q <= 1.
- Advance (no stall, no redirect): the packet is consumed. hold_valid_q <= 0; resp_pc_q <= pc_q; resp_valid_q <= 1; pc_q <= pc_q+PC_STEP.
- Latency: address issued in cycle N gives a packet in N+1. After a stall release there are no bubbles, and sequential stream order is preserved.
- First cycle after reset deassert: if_valid=0. The packet for RESET_PC appears the next cycle.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Misaligned redirect target: the address is still issued (RAM ignores [1:0]) and the packet is flagged with if_adel=1. The stream continues at target+4; decode/exception logic redirects.
- Reset asserted mid-stall or mid-redirect: all state cleared immediately; the hold packet is discarded.

Decomposition:
- Shared package holds:
  - RESET_PC default
  - PC_STEP constant
  - fetch packet typedef struct {valid, pc[31:0], inst[31:0], adel}, reused by decode.
- One natural sub-module: inst_hold_buffer. It is the single-entry capture register plus output mux, with inputs capture/clear and in/out fetch packets.

Test Plan:
1. Release reset, stall=0, RAM preloaded with word k = 32'h1000_0000+k: first cycle if_valid=0. Next cycles show if_pc = BFC0_0000, BFC0_0004, BFC0_0008 with matching words, one per cycle.
2. Stall high 3 cycles while packet pc=BFC0_0008 is shown: if_pc/if_inst stay BFC0_0008 throughout. After release the next cycles show BFC0_0008 (consumed), then BFC0_000C, then BFC0_0010, with no gap or duplicate.
3. Redirect to 8000_0100 while sequential: inst_addr=8000_0100 in that cycle, next packet if_pc=8000_0100, then 8000_0104.
4. Redirect to 8000_0200 with stall=1 and hold_valid set: hold discarded; next packet if_pc=8000_0200, if_valid=1.
5. Redirect to 8000_0102: packet if_pc=8000_0102, if_adel=1, inst = word at 8000_0100; next packet 8000_0106 with if_adel=1.
6. Assert rst during a 2-cycle stall: if_valid=0 immediately. After release the fetch restarts at BFC0_0000.
